// File: rtl/biriscv_mul_issue_ctrl_pkg.sv
// Shared defs for the multiplier issue controller: M-extension opcode match/mask
// constants, request/stage record types and the MULT_STAGES legality check.
package biriscv_mul_issue_ctrl_pkg;

  localparam logic [31:0] INST_MUL         = 32'h02000033;
  localparam logic [31:0] INST_MUL_MASK    = 32'hfe00707f;
  localparam logic [31:0] INST_MULH        = 32'h02001033;
  localparam logic [31:0] INST_MULH_MASK   = 32'hfe00707f;
  localparam logic [31:0] INST_MULHSU      = 32'h02002033;
  localparam logic [31:0] INST_MULHSU_MASK = 32'hfe00707f;
  localparam logic [31:0] INST_MULHU       = 32'h02003033;
  localparam logic [31:0] INST_MULHU_MASK  = 32'hfe00707f;

  localparam int PIPE_ID_W = 1;
  localparam int NUM_PIPES = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] opcode;
    logic [4:0]  rd_idx;
    logic [31:0] ra;
    logic [31:0] rb;
  } mul_req_t;

  typedef struct packed {
    logic [PIPE_ID_W-1:0] pipe;
    logic [4:0]           rd_idx;
    logic [31:0]          value;
  } mul_stage_t;

  function automatic logic mult_stages_legal(input int n);
    return (n == 2) || (n == 3);
  endfunction

  function automatic logic is_mul_op(input logic [31:0] op);
    return ((op & INST_MUL_MASK)    == INST_MUL)    ||
           ((op & INST_MULH_MASK)   == INST_MULH)   ||
           ((op & INST_MULHSU_MASK) == INST_MULHSU) ||
           ((op & INST_MULHU_MASK)  == INST_MULHU);
  endfunction

endpackage

// File: rtl/biriscv_mul_arb2.sv
// Two-way multiplier grant. Pipe0 wins contention unless BIRISCV_MUL_RR_EN is
// defined, in which case a pointer alternates the preferred pipe.
module biriscv_mul_arb2 (
`ifdef BIRISCV_MUL_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic valid0,
  input  logic valid1,
  input  logic hold,
  input  logic flush,
  output logic grant0,
  output logic grant1
);

  logic go;
  assign go = ~hold & ~flush;

`ifdef BIRISCV_MUL_RR_EN
  logic both;
  logic rr_q;  // preferred pipe when both request

  assign both   = valid0 & valid1;
  assign grant0 = go & valid0 & (~valid1 | ~rr_q);
  assign grant1 = go & valid1 & (~valid0 |  rr_q);

  // Only contended grants move the pointer.
  always_ff @(posedge clk) begin
    if (rst)            rr_q <= 1'b0;
    else if (go & both) rr_q <= ~rr_q;
  end
`else
  assign grant0 = go & valid0;
  assign grant1 = go & valid1 & ~valid0;
`endif

endmodule

// File: rtl/biriscv_mul_issue_ctrl.sv
// Shares one combinational multiplier between the two issue pipes and carries
// results through a MULT_STAGES-1 deep result pipeline (E2[,E3]).
// Macro BIRISCV_MUL_RR_EN: round-robin on contention (default pipe0 priority).
module biriscv_mul_issue_ctrl
  import biriscv_mul_issue_ctrl_pkg::*;
#(
  parameter int MULT_STAGES = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,

  input  logic                         req0_valid_i,
  input  logic [31:0]                  req0_opcode_i,
  input  logic [4:0]                   req0_rd_idx_i,
  input  logic [31:0]                  req0_ra_i,
  input  logic [31:0]                  req0_rb_i,
  output logic                         req0_ready_o,

  input  logic                         req1_valid_i,
  input  logic [31:0]                  req1_opcode_i,
  input  logic [4:0]                   req1_rd_idx_i,
  input  logic [31:0]                  req1_ra_i,
  input  logic [31:0]                  req1_rb_i,
  output logic                         req1_ready_o,

  input  logic                         hold_i,
  input  logic                         flush_i,

  output logic [31:0]                  mul_opcode_o,
  output logic [31:0]                  mul_ra_o,
  output logic [31:0]                  mul_rb_o,
  input  logic [31:0]                  mul_result_i,

  output logic                         wb_valid_o,
  output logic                         wb_pipe_o,
  output logic [4:0]                   wb_rd_idx_o,
  output logic [31:0]                  wb_value_o,

  output logic [MULT_STAGES-2:0]       inflight_valid_o,
  output logic [5*(MULT_STAGES-1)-1:0] inflight_rd_o
);

  localparam int STG = MULT_STAGES - 1;

  if (!mult_stages_legal(MULT_STAGES)) begin : g_bad_stages
    $error("biriscv_mul_issue_ctrl: MULT_STAGES must be 2 or 3");
  end

  mul_req_t [NUM_PIPES-1:0] req;
  logic     [NUM_PIPES-1:0] grant;

  // Requests are masked during reset so nothing is granted or driven then.
  assign req[0] = mul_req_t'{valid: req0_valid_i & ~rst_i, opcode: req0_opcode_i,
                             rd_idx: req0_rd_idx_i, ra: req0_ra_i, rb: req0_rb_i};
  assign req[1] = mul_req_t'{valid: req1_valid_i & ~rst_i, opcode: req1_opcode_i,
                             rd_idx: req1_rd_idx_i, ra: req1_ra_i, rb: req1_rb_i};

  biriscv_mul_arb2 u_arb (
`ifdef BIRISCV_MUL_RR_EN
    .clk    (clk_i),
    .rst    (rst_i),
`endif
    .valid0 (req[0].valid),
    .valid1 (req[1].valid),
    .hold   (hold_i),
    .flush  (flush_i),
    .grant0 (grant[0]),
    .grant1 (grant[1])
  );

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  // Grants are one-hot; an idle multiplier sees all-zero inputs.
  logic [4:0] sel_rd;
  always_comb begin
    mul_opcode_o = '0;
    mul_ra_o     = '0;
    mul_rb_o     = '0;
    sel_rd       = '0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      if (grant[p]) begin
        mul_opcode_o = req[p].opcode;
        mul_ra_o     = req[p].ra;
        mul_rb_o     = req[p].rb;
        sel_rd       = req[p].rd_idx;
      end
    end
  end

  mul_stage_t e2_d;
  always_comb begin
    e2_d = '0;
    if (|grant) begin
      e2_d.pipe   = grant[1];
      e2_d.rd_idx = sel_rd;
      e2_d.value  = mul_result_i;
    end
  end

  logic       [STG-1:0] vld_pipe;
  mul_stage_t [STG-1:0] stg_q;

  // Flush wins over hold; hold freezes every stage.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_pipe <= '0;
      stg_q    <= '0;
    end else if (!hold_i) begin
      vld_pipe[0] <= |grant;
      stg_q[0]    <= e2_d;
      for (int k = 1; k < STG; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        stg_q[k]    <= stg_q[k-1];
      end
    end
  end

  assign wb_valid_o  = vld_pipe[STG-1];
  assign wb_pipe_o   = stg_q[STG-1].pipe;
  assign wb_rd_idx_o = stg_q[STG-1].rd_idx;
  assign wb_value_o  = stg_q[STG-1].value;

  assign inflight_valid_o = vld_pipe;
  for (genvar k = 0; k < STG; k++) begin : g_infl
    assign inflight_rd_o[5*k +: 5] = stg_q[k].rd_idx;
  end

endmodule
